// File: rtl/egress_port_if.sv
// Downstream valid/ready stream carrying one tagged byte per transfer out of an egress port.
// The master drives the head byte and its source tag; the slave returns ready.
interface egress_port_if;
   logic [7:0] out_data;
   logic [1:0] out_src;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output out_data,
      output out_src,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_src,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/egress_port.sv
// Crossbar output endpoint: captures the granted mux byte one cycle after the scheduler strobe,
// filters misroutes and overflow, buffers in a tagged circular FIFO and drains over valid/ready.
module egress_port #(
   parameter int         DEPTH   = 4,
   parameter logic [1:0] PORT_ID = 2'b01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  sel,
   input  logic [7:0]  din,
   egress_port_if.master dn,
   output logic        full,
   output logic [15:0] pkt_cnt,
   output logic [7:0]  drop_cnt,
   output logic        misroute
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic          capPend_q, capPend_d;
   logic [1:0]    capSel_q, capSel_d;
   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   pktCnt_q, pktCnt_d;
   logic [7:0]    dropCnt_q, dropCnt_d;
   logic          misroute_q, misroute_d;
   logic [9:0]    mem [DEPTH];

   logic isEmpty, isFull, popFire, badGrant, overflow, pushFire, dropFire;

   // A full buffer still accepts a capture when the head leaves in the same cycle.
   always_comb begin
      isEmpty  = (count_q == '0);
      isFull   = (count_q == FULL_COUNT);
      popFire  = !isEmpty && dn.out_ready;
      badGrant = capPend_q && ((capSel_q == 2'b00) || (din[1:0] != PORT_ID));
      overflow = capPend_q && !badGrant && isFull && !popFire;
      pushFire = capPend_q && !badGrant && !overflow;
      dropFire = badGrant || overflow;

      capPend_d  = en;
      capSel_d   = sel;
      wrPtr_d    = pushFire ? wrPtr_q + AW'(1) : wrPtr_q;
      rdPtr_d    = popFire  ? rdPtr_q + AW'(1) : rdPtr_q;
      count_d    = count_q;
      if (pushFire && !popFire) begin
         count_d = count_q + (AW+1)'(1);
      end else if (popFire && !pushFire) begin
         count_d = count_q - (AW+1)'(1);
      end
      pktCnt_d   = (popFire && (pktCnt_q != 16'hFFFF)) ? pktCnt_q + 16'd1 : pktCnt_q;
      dropCnt_d  = (dropFire && (dropCnt_q != 8'hFF)) ? dropCnt_q + 8'd1 : dropCnt_q;
      misroute_d = misroute_q || badGrant;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         capPend_q  <= 1'b0;
         capSel_q   <= 2'b00;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         pktCnt_q   <= 16'h0000;
         dropCnt_q  <= 8'h00;
         misroute_q <= 1'b0;
      end else begin
         capPend_q  <= capPend_d;
         capSel_q   <= capSel_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         pktCnt_q   <= pktCnt_d;
         dropCnt_q  <= dropCnt_d;
         misroute_q <= misroute_d;
      end
   end

   // Storage is left unreset; the empty gating below keeps stale contents invisible.
   always_ff @(posedge clk) begin
      if (pushFire) begin
         mem[wrPtr_q] <= {capSel_q, din};
      end
   end

   assign dn.out_valid = !isEmpty;
   assign dn.out_data  = isEmpty ? 8'h00 : mem[rdPtr_q][7:0];
   assign dn.out_src   = isEmpty ? 2'b00 : mem[rdPtr_q][9:8];
   assign full         = isFull;
   assign pkt_cnt      = pktCnt_q;
   assign drop_cnt     = dropCnt_q;
   assign misroute     = misroute_q;

endmodule

// File: doc/egress_port.md
# egress_port

Output-side endpoint of the 3x3 crossbar. One instance per output port. It takes the per-port enable/select strobe from the scheduler and captures the crossbar mux output one cycle later, which matches the 1-cycle read latency of the ingress FIFOs. Captured bytes go into a small tagged FIFO and drain downstream over a valid/ready handshake. Misrouted and overflow packets are dropped and counted.

## Interface
Parameters:
- DEPTH, 4 — buffer entries; power of two, 2..16.
- PORT_ID, 2'b01 — this output's destination code (01/10/11).

Ports:
- clk  in  1  Single clock; all state changes on posedge clk.
- rst_n  in  1  Reset is synchronous and active-low.
- en  in  1  Scheduler enable for this port; asserted for one cycle when a packet is granted.
- sel  in  2  Granted input port (01/10/11), valid with en.
- din  in  8  Crossbar mux output; valid in the cycle after en.
- out_data  out  8  Head-of-buffer packet byte.
- out_src  out  2  Input port the head packet came from.
- out_valid  out  1  Buffer non-empty.
- out_ready  in  1  Downstream accepts head this cycle.
- full  out  1  Buffer holds DEPTH entries.
- pkt_cnt  out  16  Packets delivered downstream; saturating.
- drop_cnt  out  8  Packets dropped (overflow or misroute); saturating.
- misroute  out  1  Sticky; set on any bad grant or address mismatch.

## Operation
- Capture stage: en and sel are registered into cap_pend and cap_sel. In the following cycle, if cap_pend=1, din is evaluated together with cap_sel.
- Capture check, in priority order:
  - cap_sel==2'b00 → drop, set misroute, increment drop_cnt.
  - din[1:0]!=PORT_ID → drop, set misroute, increment drop_cnt.
  - Buffer full and no pop this cycle → drop, increment drop_cnt. misroute is unchanged.
  - Otherwise push {cap_sel, din}.
- en asserted on back-to-back cycles is legal. Each pulse captures independently, one cycle later; the pipeline is fully overlapped.
- Buffer: circular, with DEPTH entries of 10 bits. Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Pop: when out_valid && out_ready, the read pointer advances and pkt_cnt increments.
- Simultaneous push and pop: count is unchanged. This is allowed when full, because the pop frees the slot in the same cycle, so there is no drop.
- Push into an empty buffer with out_ready=1: the entry is written and is not presented until the next cycle. There is no combinational bypass.
- out_data, out_src, out_valid, and full are driven from registered state only. Nothing is combinational from inputs.
- Counters saturate: pkt_cnt at 16'hFFFF, drop_cnt at 8'hFF. They never wrap.
- misroute clears only on reset.

## Timing
- Reset (rst_n=0 at posedge): pointers, count, cap_pend, cap_sel, pkt_cnt, drop_cnt, and misroute all go to 0. As a result out_valid=0, full=0, out_data=0, out_src=0. Buffer contents need not be cleared, but out_data must read 0 while empty after reset.
- Reset in the middle of a capture (en seen, rst_n low in the next cycle): the pending capture is discarded and nothing is counted.
- Latency:
  - en at edge N; din sampled at edge N+1.
  - out_valid is high after edge N+1, so visible in cycle N+1→N+2.
  - Minimum en-to-out_valid is 2 cycles.
- Throughput: one push and one pop per cycle.
- Every captured packet is either buffered or counted in drop_cnt; it is never silently lost.
- out_valid stays high and out_data/out_src hold stable until popped (standard valid/ready; no retraction).

## Test plan
- Reset, then en=1 with sel=10. Next cycle din=8'hA5 with PORT_ID=01, out_ready=1 → two cycles later out_valid=1, out_data=A5, out_src=10. One cycle after that, pkt_cnt=1 and out_valid=0.
- out_ready=0, then 5 grants with din=8'h11, 21, 31, 41, 51 (DEPTH=4) → full=1 after the 4th push, the 5th is dropped and drop_cnt=1, misroute=0. Then out_ready=1 → drains in order 11, 21, 31, 41.
- Full buffer with out_ready=1 and a grant in the same cycle (din=8'h61) → no drop, count stays 4, and 61 emerges 4th after the entries already queued.
- Grant with din=8'h02 at PORT_ID=01, then a grant with sel=00 → both dropped, drop_cnt=2, misroute=1. misroute stays 1 through 20 idle cycles and clears only on rst_n=0.
- en high for 8 consecutive cycles with sel=01,10,11 repeating, valid din, out_ready=1 → 8 packets out in order on 8 consecutive cycles, pkt_cnt=8, drop_cnt=0.
- en=1 at cycle N, rst_n=0 at N+1 → after reset, out_valid=0, pkt_cnt=0, drop_cnt=0, and no stray output.
